// File: rtl/queue_bank4.sv
// queue_bank4 -- four independent synchronous FIFOs behind the pop scheduler.
//
// Writers push words into the queue selected by push_id. The scheduler pops
// through pop_valid/pop_id, and the popped word appears registered on data_out
// one cycle later, qualified by data_out_valid.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   push/push_id/data_in      push request into queue push_id
//   pop_valid/pop_id          pop command from the scheduler
//   data_out/data_out_valid   popped word, 1-cycle latency, holds when idle
//   empty[3:0], full[3:0]     per-queue flags, bit n = queue n
//   overflow, underflow       sticky error flags, cleared only by reset
//   almost_full[3:0]          count >= AF_THRESH, only when the macro
//                             QUEUE_BANK_ALMOST_FULL_EN is defined
//
// Flags are registered from the next-state count, so they already describe the
// queue after this cycle's push/pop. A full queue accepts a push in the same
// cycle it is popped; an empty queue rejects the pop even if pushed that cycle.

module queue_bank4_lane #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head,
`ifdef QUEUE_BANK_ALMOST_FULL_EN
  output logic             almost_full,
`endif
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count, count_nxt;
  logic             push_ok, pop_ok;

  // A full queue being popped this cycle frees the slot the push lands in.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
`ifdef QUEUE_BANK_ALMOST_FULL_EN
      almost_full <= 1'b0;
`endif
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
`ifdef QUEUE_BANK_ALMOST_FULL_EN
      almost_full <= (count_nxt >= AF_THRESH[AW:0]);
`endif
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wptr] <= data_in;
  end
endmodule

module queue_bank4 #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [1:0]       push_id,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop_valid,
  input  logic [1:0]       pop_id,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  output logic [3:0]       empty,
  output logic [3:0]       full,
`ifdef QUEUE_BANK_ALMOST_FULL_EN
  output logic [3:0]       almost_full,
`endif
  output logic             overflow,
  output logic             underflow
);
  logic [3:0][WIDTH-1:0] heads;
  logic                  pop_hit, pop_miss, push_drop;

  for (genvar n = 0; n < 4; n++) begin : g_q
    queue_bank4_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .push        (push && (push_id == n[1:0])),
      .pop         (pop_valid && (pop_id == n[1:0])),
      .data_in     (data_in),
      .head        (heads[n]),
`ifdef QUEUE_BANK_ALMOST_FULL_EN
      .almost_full (almost_full[n]),
`endif
      .empty       (empty[n]),
      .full        (full[n])
    );
  end

  assign pop_hit   = pop_valid & ~empty[pop_id];
  assign pop_miss  = pop_valid &  empty[pop_id];
  // A push to a full queue is only dropped when that queue is not popped too.
  assign push_drop = push & full[push_id] & ~(pop_valid && (pop_id == push_id));

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      data_out_valid <= pop_hit;
      if (pop_hit)   data_out  <= heads[pop_id];
      if (push_drop) overflow  <= 1'b1;
      if (pop_miss)  underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_queue_bank4.sv
// Randomised and directed bench for queue_bank4. A queue-of-queues reference
// model predicts every pop; expected words go to a scoreboard that a separate
// monitor drains whenever data_out_valid is seen.
module tb_queue_bank4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             push = 1'b0;
  logic [1:0]       push_id = '0;
  logic [WIDTH-1:0] data_in = '0;
  logic             pop_valid = 1'b0;
  logic [1:0]       pop_id = '0;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;
  logic [3:0]       empty, full;
  logic             overflow, underflow;
`ifdef QUEUE_BANK_ALMOST_FULL_EN
  logic [3:0]       almost_full;
`endif

  queue_bank4 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_id        (push_id),
    .data_in        (data_in),
    .pop_valid      (pop_valid),
    .pop_id         (pop_id),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .empty          (empty),
    .full           (full),
`ifdef QUEUE_BANK_ALMOST_FULL_EN
    .almost_full    (almost_full),
`endif
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mq [4][$];   // reference contents per queue
  logic [WIDTH-1:0] sb [$];      // scoreboard of expected popped words
  logic             m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
  logic [WIDTH-1:0] m_last = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every valid word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (data_out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_pop: got %0h expected none", data_out);
      end else begin
        chk("pop_data", {24'h0, data_out}, {24'h0, sb.pop_front()});
      end
    end
  end

  // One clock of stimulus; the model applies the pop (against pre-cycle
  // contents) before the push, which is exactly what makes a full queue
  // accept a push while being popped and an empty one reject the pop.
  task automatic step(input bit r, input bit ps, input int pid, input logic [WIDTH-1:0] d,
                      input bit pv, input int qid);
    logic [3:0] e_emp, e_full, e_af;
    @(negedge clk);
    reset = r; push = ps; push_id = pid[1:0]; data_in = d;
    pop_valid = pv; pop_id = qid[1:0];
    m_vld = 1'b0;
    if (r) begin
      for (int q = 0; q < 4; q++) mq[q].delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
    end else begin
      if (pv) begin
        if (mq[qid].size() > 0) begin
          m_last = mq[qid].pop_front();
          sb.push_back(m_last);
          m_vld = 1'b1;
        end else m_unf = 1'b1;
      end
      if (ps) begin
        if (mq[pid].size() < DEPTH) mq[pid].push_back(d);
        else m_ovf = 1'b1;
      end
    end
    for (int q = 0; q < 4; q++) begin
      e_emp[q]  = (mq[q].size() == 0);
      e_full[q] = (mq[q].size() == DEPTH);
      e_af[q]   = (mq[q].size() >= AFT);
    end
    @(posedge clk); #1;
    chk("empty", {28'h0, empty}, {28'h0, e_emp});
    chk("full", {28'h0, full}, {28'h0, e_full});
    chk("data_out_valid", {31'h0, data_out_valid}, {31'h0, m_vld});
    chk("data_out", {24'h0, data_out}, {24'h0, m_last});
    chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    chk("underflow", {31'h0, underflow}, {31'h0, m_unf});
`ifdef QUEUE_BANK_ALMOST_FULL_EN
    chk("almost_full", {28'h0, almost_full}, {28'h0, e_af});
`else
    if (e_af === 4'hx) $display("unreachable");
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    step(1, 0, 0, '0, 0, 0);
    idle();
    // Two words through queue 2
    step(0, 1, 2, 8'hA1, 0, 0);
    step(0, 1, 2, 8'hA2, 0, 0);
    step(0, 0, 0, '0, 1, 2);
    step(0, 0, 0, '0, 1, 2);
    idle();
    // Fill queue 0, overflow, drain, then refill to exercise pointer wrap
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h10 + i[7:0], 0, 0);
    step(0, 1, 0, 8'hFF, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h20 + i[7:0], 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1, 0);
    // Full queue 1: simultaneous push and pop keeps it full
    for (int i = 0; i < 8; i++) step(0, 1, 1, 8'h40 + i[7:0], 0, 0);
    step(0, 1, 1, 8'h55, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1, 1);
    // Empty queue 3: pop rejected, push accepted, no bypass
    step(0, 1, 3, 8'h33, 1, 3);
    step(0, 0, 0, '0, 1, 3);
    // Reset with data queued and a pop in flight
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h60 + i[7:0], 0, 0);
    step(0, 0, 0, '0, 1, 0);
    step(1, 1, 0, 8'h77, 1, 0);
    idle();
    // Six words into queue 0 reaches the almost-full threshold
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h80 + i[7:0], 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1, 0);
    // Random traffic: fill-biased phase, then drain-biased phase
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit ps, pv, r;
        ps = ($urandom_range(99) < ((ph % 2 == 0) ? 80 : 30));
        pv = ($urandom_range(99) < ((ph % 2 == 0) ? 30 : 80));
        r  = ($urandom_range(199) == 0);
        step(r, ps, $urandom_range(3), WIDTH'($urandom), pv, $urandom_range(3));
      end
    end
    idle();
    idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
